// File: rtl/sample_window.sv
// sample_window: sliding window of signed samples with absolute indices, emitted every STRIDE accepts
module sample_window #(
  parameter int WINDOW_SIZE = 7,
  parameter int STRIDE = 1,
  parameter logic [31:0] IDX_RESET = '0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic flush,
  input  logic in_valid,
  output logic in_ready,
  input  logic signed [31:0] in_data,
  output logic win_valid,
  input  logic win_ready,
  output logic signed [31:0] win_data [0:WINDOW_SIZE-1],
  output logic signed [31:0] win_x [0:WINDOW_SIZE-1],
  output logic [31:0] win_count
);
  typedef enum logic [1:0] {FILL, STREAM, EMIT} state_t;
  state_t state;
  logic signed [31:0] sh_data [0:WINDOW_SIZE-1];
  logic signed [31:0] sh_x [0:WINDOW_SIZE-1];
  logic [31:0] fill_cnt, stride_cnt, sample_idx;
  logic acc, fire;
  assign in_ready = ~win_valid | win_ready;
  assign acc = in_valid & in_ready & ~flush;
  assign fire = (state == EMIT) & in_ready;
  // shift register of samples and their indices; index counter survives flush
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < WINDOW_SIZE; i++) begin
        sh_data[i] <= '0;
        sh_x[i] <= '0;
      end
      sample_idx <= IDX_RESET;
    end else if (acc) begin
      for (int i = 0; i < WINDOW_SIZE-1; i++) begin
        sh_data[i] <= sh_data[i+1];
        sh_x[i] <= sh_x[i+1];
      end
      sh_data[WINDOW_SIZE-1] <= in_data;
      sh_x[WINDOW_SIZE-1] <= sample_idx;
      sample_idx <= sample_idx + 32'd1;
    end
  end
  // fill/stride sequencing and registered window outputs; EMIT waits until the held window is taken
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= FILL;
      fill_cnt <= '0;
      stride_cnt <= '0;
      win_valid <= 1'b0;
      win_count <= '0;
      for (int i = 0; i < WINDOW_SIZE; i++) begin
        win_data[i] <= '0;
        win_x[i] <= '0;
      end
    end else if (flush) begin
      state <= FILL;
      fill_cnt <= '0;
      stride_cnt <= '0;
      win_valid <= 1'b0;
      win_count <= '0;
    end else begin
      if (fire) begin
        win_data <= sh_data;
        win_x <= sh_x;
        win_valid <= 1'b1;
        win_count <= win_count + 32'd1;
      end else if (win_ready) begin
        win_valid <= 1'b0;
      end
      case (state)
        FILL: if (acc) begin
          fill_cnt <= fill_cnt + 32'd1;
          stride_cnt <= '0;
          state <= (fill_cnt == 32'(WINDOW_SIZE-1)) ? EMIT : FILL;
        end
        STREAM: if (acc) begin
          stride_cnt <= (stride_cnt == 32'(STRIDE-1)) ? '0 : stride_cnt + 32'd1;
          state <= (stride_cnt == 32'(STRIDE-1)) ? EMIT : STREAM;
        end
        default: if (fire) begin
          stride_cnt <= (acc && STRIDE > 1) ? 32'd1 : '0;
          state <= (acc && STRIDE == 1) ? EMIT : STREAM;
        end
      endcase
    end
  end
endmodule
